// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM / memory-mapped IO bus arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } state_e;

  // Strobe encodings, bit order {ce_n, oe_n, we_n, lb_n, ub_n}
  localparam logic [4:0] CTRL_IDLE  = 5'b11111;
  localparam logic [4:0] CTRL_SETUP = 5'b01100;
  localparam logic [4:0] CTRL_READ  = 5'b00100;
  localparam logic [4:0] CTRL_WRITE = 5'b01000;

  // Port indices as carried by the grant / last_grant flops
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Wait counter width, enough for the 1..15 wait-state range
  localparam int unsigned CNT_W = 4;

  // Active strobe pattern for the ACCESS phase of a read or a write
  function automatic logic [4:0] access_ctrl(input logic we);
    return we ? CTRL_WRITE : CTRL_READ;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection between the two requesters.
// SRAM_ARB_ROUND_ROBIN_EN defined : contention goes to the port that was not granted last.
// SRAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

`ifndef SRAM_ARB_ROUND_ROBIN_EN
  // Fixed priority ignores the grant history
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Pick the winning port among the active requests
  always_comb begin
    valid = req0 | req1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    if (req0 && req1) begin
      grant = ~last_grant;
    end else begin
      grant = req1 ? PORT1 : PORT0;
    end
`else
    grant = req0 ? PORT0 : (req1 ? PORT1 : PORT0);
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and SETUP/ACCESS/HOLD access sequencer for the external
// SRAM / memory-mapped IO bus. Arbitration policy selected by the macro
// SRAM_ARB_ROUND_ROBIN_EN inside sram_arb_pick (default: fixed priority).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [4:0]        sram_control,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_doe,
  input  logic [DATA_W-1:0] sram_din
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [4:0]        ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              doe_q, doe_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic pick_valid;
  logic pick_grant;

  sram_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  // Next-state and next-output logic; every bus output is computed one
  // state ahead so the registered value lines up with the state it belongs to.
  // The latched address and write data live directly in the bus output flops.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ctrl_d       = ctrl_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    doe_d        = doe_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          we_d    = (pick_grant == PORT1) ? we1    : we0;
          addr_d  = (pick_grant == PORT1) ? addr1  : addr0;
          dout_d  = (pick_grant == PORT1) ? wdata1 : wdata0;
          doe_d   = we_d;
          ctrl_d  = CTRL_SETUP;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_LOAD;
        ctrl_d  = access_ctrl(we_q);
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          ctrl_d       = CTRL_IDLE;
          doe_d        = 1'b0;
          ack0_d       = (grant_q == PORT0);
          ack1_d       = (grant_q == PORT1);
          last_grant_d = grant_q;
          if (!we_q) begin
            rdata_d = sram_din;
          end
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        ctrl_d  = CTRL_IDLE;
        doe_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      grant_q      <= PORT0;
      last_grant_q <= PORT1;
      ctrl_q       <= CTRL_IDLE;
      addr_q       <= '0;
      dout_q       <= '0;
      doe_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      ctrl_q       <= ctrl_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      doe_q        <= doe_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata_q      <= rdata_d;
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign rdata        = rdata_q;
  assign busy         = (state_q != IDLE);
  assign sram_addr    = addr_q;
  assign sram_control = ctrl_q;
  assign sram_dout    = dout_q;
  assign sram_doe     = doe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter (WAIT_CYCLES = 2 main instance, plus
// WAIT_CYCLES = 1 and 15 instances for latency checks).
module tb_sram_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [17:0] addr0, addr1;
  logic [15:0] wdata0, wdata1, sram_din;
  logic        ack0, ack1, busy, sram_doe;
  logic [15:0] rdata, sram_dout;
  logic [17:0] sram_addr;
  logic [4:0]  sram_control;

  logic        req0_a, ack0_a, ack1_a, busy_a, doe_a;
  logic [15:0] rdata_a, dout_a;
  logic [17:0] addr_a;
  logic [4:0]  ctrl_a;
  logic        req0_b, ack0_b, ack1_b, busy_b, doe_b;
  logic [15:0] rdata_b, dout_b;
  logic [17:0] addr_b;
  logic [4:0]  ctrl_b;

  int checks = 0;
  int errors = 0;

  sram_arbiter #(.WAIT_CYCLES(2), .ADDR_W(18), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .busy(busy), .sram_addr(sram_addr), .sram_control(sram_control),
    .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din)
  );

  sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(18), .DATA_W(16)) u_w1 (
    .clk(clk), .reset(reset),
    .req0(req0_a), .we0(1'b0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_a),
    .req1(1'b0), .we1(1'b0), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_a),
    .rdata(rdata_a), .busy(busy_a), .sram_addr(addr_a), .sram_control(ctrl_a),
    .sram_dout(dout_a), .sram_doe(doe_a), .sram_din(sram_din)
  );

  sram_arbiter #(.WAIT_CYCLES(15), .ADDR_W(18), .DATA_W(16)) u_w15 (
    .clk(clk), .reset(reset),
    .req0(req0_b), .we0(1'b0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_b),
    .req1(1'b0), .we1(1'b0), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_b),
    .rdata(rdata_b), .busy(busy_b), .sram_addr(addr_b), .sram_control(ctrl_b),
    .sram_dout(dout_b), .sram_doe(doe_b), .sram_din(sram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, a0, a1, both, la, lb, sa, sb;
    int seq [10];

    // ---- 1: reset held with a pending request ----
    reset = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 18'h0; wdata0 = 16'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 18'h0; wdata1 = 16'h0;
    sram_din = 16'h1234; req0_a = 1'b0; req0_b = 1'b0;
    #12;
    check("rst_ctrl", sram_control, 5'b11111);
    check("rst_doe", sram_doe, 1'b0);
    check("rst_acks", {ack0, ack1}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_addr", sram_addr, 18'h0);
    tick;
    reset = 1'b1;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (ack0) begin lat = i; break; end
    end
    check("t1_latency", lat, 4);
    check("t1_rdata", rdata, 16'h1234);
    req0 = 1'b0;
    tick;
    check("t1_ack_pulse", ack0, 1'b0);
    check("t1_idle", busy, 1'b0);

    // ---- 2: port 0 write then port 1 read of the same address ----
    req0 = 1'b1; we0 = 1'b1; addr0 = 18'h00010; wdata0 = 16'hBEEF;
    tick;
    check("t2w_setup_ctrl", sram_control, 5'b01100);
    check("t2w_setup_doe", sram_doe, 1'b1);
    check("t2w_setup_addr", sram_addr, 18'h00010);
    check("t2w_setup_dout", sram_dout, 16'hBEEF);
    check("t2w_busy", busy, 1'b1);
    tick;
    check("t2w_acc1", sram_control, 5'b01000);
    check("t2w_acc1_ack", ack0, 1'b0);
    tick;
    check("t2w_acc2", sram_control, 5'b01000);
    tick;
    check("t2w_hold_ctrl", sram_control, 5'b11111);
    check("t2w_hold_ack", {ack0, ack1}, 2'b10);
    check("t2w_hold_doe", sram_doe, 1'b0);
    check("t2w_rdata_kept", rdata, 16'h1234);
    req0 = 1'b0;
    tick;
    check("t2w_ack_drop", ack0, 1'b0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 18'h00010; sram_din = 16'hBEEF;
    tick;
    check("t2r_setup_ctrl", sram_control, 5'b01100);
    check("t2r_setup_doe", sram_doe, 1'b0);
    tick;
    check("t2r_acc1", sram_control, 5'b00100);
    tick;
    check("t2r_acc2", sram_control, 5'b00100);
    tick;
    check("t2r_hold_ack", {ack0, ack1}, 2'b01);
    check("t2r_rdata", rdata, 16'hBEEF);
    req1 = 1'b0;
    tick;

    // ---- 3: both ports requesting continuously ----
    req0 = 1'b1; we0 = 1'b0; addr0 = 18'h00100;
    req1 = 1'b1; we1 = 1'b0; addr1 = 18'h00200;
    n = 0; a0 = 0; a1 = 0; both = 0;
    for (int i = 0; i < 100 && n < 10; i++) begin
      tick;
      if (ack0 && ack1) both++;
      if (ack0) begin seq[n] = 0; n++; a0++; end
      else if (ack1) begin seq[n] = 1; n++; a1++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("t3_count", n, 10);
    check("t3_no_double_ack", both, 0);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    check("t3_seq0", seq[0], 0);
    check("t3_seq1", seq[1], 1);
    check("t3_seq2", seq[2], 0);
    check("t3_seq3", seq[3], 1);
    check("t3_acks0", a0, 5);
    check("t3_acks1", a1, 5);
`else
    check("t3_acks0", a0, 10);
    check("t3_acks1", a1, 0);
`endif
    tick;

    // ---- 4: addr change and req drop mid-transaction ----
    req0 = 1'b1; we0 = 1'b0; addr0 = 18'h00020; sram_din = 16'h5A5A;
    tick;
    tick;
    addr0 = 18'h3FFFF; req0 = 1'b0;
    tick;
    check("t4_addr_held", sram_addr, 18'h00020);
    check("t4_acc_ctrl", sram_control, 5'b00100);
    tick;
    check("t4_ack", ack0, 1'b1);
    check("t4_hold_addr", sram_addr, 18'h00020);
    check("t4_rdata", rdata, 16'h5A5A);
    tick;
    check("t4_idle", busy, 1'b0);
    tick;
    check("t4_no_new", {busy, ack0}, 2'b00);

    // ---- 5: reset during the ACCESS phase of a write ----
    req1 = 1'b1; we1 = 1'b1; addr1 = 18'h00033; wdata1 = 16'h1111;
    tick;
    check("t5_setup_doe", sram_doe, 1'b1);
    tick;
    check("t5_acc_ctrl", sram_control, 5'b01000);
    #2 reset = 1'b0;
    #1;
    check("t5_async_ctrl", sram_control, 5'b11111);
    check("t5_async_doe", sram_doe, 1'b0);
    check("t5_async_addr", sram_addr, 18'h0);
    check("t5_async_dout", sram_dout, 16'h0);
    check("t5_async_busy", busy, 1'b0);
    check("t5_async_rdata", rdata, 16'h0);
    tick;
    check("t5_no_ack", {ack0, ack1}, 2'b00);
    #3 reset = 1'b1;
    tick;
    check("t5_restart_ctrl", sram_control, 5'b01100);
    check("t5_restart_addr", sram_addr, 18'h00033);
    check("t5_restart_dout", sram_dout, 16'h1111);
    tick;
    tick;
    tick;
    check("t5_restart_ack", {ack0, ack1}, 2'b01);
    req1 = 1'b0;
    tick;

    // ---- 6: wait-state extremes ----
    req0_a = 1'b1; req0_b = 1'b1;
    la = 0; lb = 0; sa = 0; sb = 0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (ctrl_a == 5'b00100) sa++;
      if (ctrl_b == 5'b00100) sb++;
      if (ack0_a && la == 0) begin la = i; req0_a = 1'b0; end
      if (ack0_b && lb == 0) begin lb = i; req0_b = 1'b0; end
    end
    check("t6_lat_w1", la, 3);
    check("t6_lat_w15", lb, 17);
    check("t6_strobe_w1", sa, 1);
    check("t6_strobe_w15", sb, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
